// File: rtl/calc_entry_ctrl.sv
// Calculator entry sequencer: turns keyboard events into two BCD operands and an
// operator, launches the ALU, supervises completion with a timeout, and picks the display source.
module calc_entry_ctrl #(
  parameter int NDIG    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [3:0]        BCDKey,
  input  logic              KeyRead,
  input  logic              ALU_DONE,
  input  logic              ALU_ERR,
  input  logic [4*NDIG-1:0] RESULT,
  output logic [4*NDIG-1:0] OPA,
  output logic [4*NDIG-1:0] OPB,
  output logic [1:0]        OPCODE,
  output logic              ALU_START,
  output logic [1:0]        DISP_SEL,
  output logic              ERR
);

  localparam int OW = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NDIG);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ENT_A,
    ENT_B,
    EXEC,
    RES,
    ERRS
  } state_t;

  state_t          r_state, w_nxt_state;
  logic [OW-1:0]   r_opa, w_nxt_opa;
  logic [OW-1:0]   r_opb, w_nxt_opb;
  logic [1:0]      r_opcode, w_nxt_opcode;
  logic            r_start, w_nxt_start;
  logic [CW-1:0]   r_cnta, w_nxt_cnta;
  logic [CW-1:0]   r_cntb, w_nxt_cntb;
  logic [TW-1:0]   r_tcnt, w_nxt_tcnt;
  logic            r_key_d;

  logic            w_ev;
  logic            w_is_dig;
  logic            w_is_op;
  logic            w_is_eq;
  logic            w_is_clr;
  logic [1:0]      w_op;

  // A held key produces a single event on its rising edge
  assign w_ev     = KeyRead & ~r_key_d;
  assign w_is_dig = (BCDKey <= 4'd9);
  assign w_is_op  = (BCDKey >= 4'd10) && (BCDKey <= 4'd13);
  assign w_is_eq  = (BCDKey == 4'd14);
  assign w_is_clr = (BCDKey == 4'd15);
  // Keys 10..13 map onto opcodes 0..3
  assign w_op     = {~BCDKey[1], BCDKey[0]};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= ENT_A;
      r_opa    <= '0;
      r_opb    <= '0;
      r_opcode <= '0;
      r_start  <= 1'b0;
      r_cnta   <= '0;
      r_cntb   <= '0;
      r_tcnt   <= '0;
      r_key_d  <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_opa    <= w_nxt_opa;
      r_opb    <= w_nxt_opb;
      r_opcode <= w_nxt_opcode;
      r_start  <= w_nxt_start;
      r_cnta   <= w_nxt_cnta;
      r_cntb   <= w_nxt_cntb;
      r_tcnt   <= w_nxt_tcnt;
      r_key_d  <= KeyRead;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_opa    = r_opa;
    w_nxt_opb    = r_opb;
    w_nxt_opcode = r_opcode;
    w_nxt_start  = 1'b0;
    w_nxt_cnta   = r_cnta;
    w_nxt_cntb   = r_cntb;
    w_nxt_tcnt   = r_tcnt;

    // Clear overrides everything, including a coincident ALU completion
    if (w_ev && w_is_clr) begin
      w_nxt_state  = ENT_A;
      w_nxt_opa    = '0;
      w_nxt_opb    = '0;
      w_nxt_opcode = '0;
      w_nxt_cnta   = '0;
      w_nxt_cntb   = '0;
      w_nxt_tcnt   = '0;
    end else begin
      case (r_state)
        ENT_A: begin
          if (w_ev) begin
            if (w_is_dig) begin
              if (r_cnta != CNT_FULL) begin
                w_nxt_opa  = {r_opa[OW-5:0], BCDKey};
                w_nxt_cnta = r_cnta + 1'b1;
              end
            end else if (w_is_op) begin
              w_nxt_opcode = w_op;
              w_nxt_opb    = '0;
              w_nxt_cntb   = '0;
              w_nxt_state  = ENT_B;
            end
          end
        end

        ENT_B: begin
          if (w_ev) begin
            if (w_is_dig) begin
              if (r_cntb != CNT_FULL) begin
                w_nxt_opb  = {r_opb[OW-5:0], BCDKey};
                w_nxt_cntb = r_cntb + 1'b1;
              end
            end else if (w_is_op) begin
              // Operator may only be revised before any B digit is typed
              if (r_cntb == '0) begin
                w_nxt_opcode = w_op;
              end
            end else if (w_is_eq && (r_cntb != '0)) begin
              w_nxt_start = 1'b1;
              w_nxt_tcnt  = '0;
              w_nxt_state = EXEC;
            end
          end
        end

        EXEC: begin
          if (ALU_DONE) begin
            w_nxt_state = ALU_ERR ? ERRS : RES;
          end else begin
            w_nxt_tcnt = r_tcnt + 1'b1;
            if (r_tcnt == TMO_LAST) begin
              w_nxt_state = ERRS;
            end
          end
        end

        RES: begin
          if (w_ev) begin
            if (w_is_dig) begin
              w_nxt_opa   = OW'(BCDKey);
              w_nxt_cnta  = CW'(1);
              w_nxt_opb   = '0;
              w_nxt_cntb  = '0;
              w_nxt_state = ENT_A;
            end else if (w_is_op) begin
              // Chain: previous result becomes a full-length operand A
              w_nxt_opa    = RESULT;
              w_nxt_cnta   = CNT_FULL;
              w_nxt_opcode = w_op;
              w_nxt_opb    = '0;
              w_nxt_cntb   = '0;
              w_nxt_state  = ENT_B;
            end else if (w_is_eq) begin
              w_nxt_opa   = RESULT;
              w_nxt_start = 1'b1;
              w_nxt_tcnt  = '0;
              w_nxt_state = EXEC;
            end
          end
        end

        ERRS: begin
        end

        default: begin
          w_nxt_state = ENT_A;
        end
      endcase
    end
  end

  always_comb begin
    DISP_SEL = 2'd0;
    case (r_state)
      ENT_A:   DISP_SEL = 2'd0;
      ENT_B:   DISP_SEL = 2'd1;
      EXEC:    DISP_SEL = 2'd1;
      RES:     DISP_SEL = 2'd2;
      ERRS:    DISP_SEL = 2'd3;
      default: DISP_SEL = 2'd0;
    endcase
  end

  assign OPA       = r_opa;
  assign OPB       = r_opb;
  assign OPCODE    = r_opcode;
  assign ALU_START = r_start;
  assign ERR       = (r_state == ERRS);

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: key sequences with hand-computed operand,
// opcode, launch and display expectations.
module tb_calc_entry_ctrl;

  logic        CLK;
  logic        RESET;
  logic [3:0]  BCDKey;
  logic        KeyRead;
  logic        ALU_DONE;
  logic        ALU_ERR;
  logic [15:0] RESULT;
  logic [15:0] OPA;
  logic [15:0] OPB;
  logic [1:0]  OPCODE;
  logic        ALU_START;
  logic [1:0]  DISP_SEL;
  logic        ERR;

  int n_chk;
  int n_fail;

  calc_entry_ctrl #(.NDIG(4), .TIMEOUT(255)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .BCDKey   (BCDKey),
    .KeyRead  (KeyRead),
    .ALU_DONE (ALU_DONE),
    .ALU_ERR  (ALU_ERR),
    .RESULT   (RESULT),
    .OPA      (OPA),
    .OPB      (OPB),
    .OPCODE   (OPCODE),
    .ALU_START(ALU_START),
    .DISP_SEL (DISP_SEL),
    .ERR      (ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    BCDKey  = k;
    KeyRead = 1'b1;
    repeat (hold) tick();
    KeyRead = 1'b0;
    tick();
  endtask

  // Equals-style press: checks the launch pulse right after the event edge and its drop
  task automatic press_eq(input logic [3:0] k, input logic exp_start, input string tag);
    BCDKey  = k;
    KeyRead = 1'b1;
    tick();
    chk({tag, "_start"}, 32'(ALU_START), 32'(exp_start));
    KeyRead = 1'b0;
    tick();
    chk({tag, "_start_drop"}, 32'(ALU_START), 32'd0);
  endtask

  task automatic alu_done(input logic [15:0] res, input logic err);
    RESULT   = res;
    ALU_ERR  = err;
    ALU_DONE = 1'b1;
    tick();
    ALU_DONE = 1'b0;
    ALU_ERR  = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    RESET    = 1'b0;
    BCDKey   = 4'd0;
    KeyRead  = 1'b0;
    ALU_DONE = 1'b0;
    ALU_ERR  = 1'b0;
    RESULT   = 16'h0000;
    tick();
    tick();
    chk("rst_opa", 32'(OPA), 32'h0);
    chk("rst_opb", 32'(OPB), 32'h0);
    chk("rst_opcode", 32'(OPCODE), 32'h0);
    chk("rst_start", 32'(ALU_START), 32'h0);
    chk("rst_disp", 32'(DISP_SEL), 32'h0);
    chk("rst_err", 32'(ERR), 32'h0);
    RESET = 1'b1;
    tick();

    // 12 + 34 =
    press(4'd1, 1);
    press(4'd2, 1);
    chk("a_12", 32'(OPA), 32'h0012);
    chk("a_disp", 32'(DISP_SEL), 32'd0);
    press(4'd10, 1);
    press(4'd3, 1);
    press(4'd4, 1);
    chk("add_opa", 32'(OPA), 32'h0012);
    chk("add_opcode", 32'(OPCODE), 32'd0);
    chk("add_opb", 32'(OPB), 32'h0034);
    chk("add_disp", 32'(DISP_SEL), 32'd1);
    press_eq(4'd14, 1'b1, "add_eq");
    chk("exec_disp", 32'(DISP_SEL), 32'd1);
    alu_done(16'h0046, 1'b0);
    chk("res_disp", 32'(DISP_SEL), 32'd2);

    // Chaining: 46 - 6 =, then repeat equals
    press(4'd11, 1);
    chk("chain_opa", 32'(OPA), 32'h0046);
    chk("chain_opcode", 32'(OPCODE), 32'd1);
    chk("chain_opb", 32'(OPB), 32'h0);
    chk("chain_disp", 32'(DISP_SEL), 32'd1);
    press(4'd6, 1);
    press_eq(4'd14, 1'b1, "chain_eq");
    alu_done(16'h0040, 1'b0);
    chk("chain_res_disp", 32'(DISP_SEL), 32'd2);
    press_eq(4'd14, 1'b1, "rep_eq");
    chk("rep_opa", 32'(OPA), 32'h0040);
    chk("rep_opb", 32'(OPB), 32'h0006);
    chk("rep_opcode", 32'(OPCODE), 32'd1);
    chk("rep_disp", 32'(DISP_SEL), 32'd1);
    alu_done(16'h0034, 1'b0);
    chk("rep_res_disp", 32'(DISP_SEL), 32'd2);

    // Clear, then held keys and digit overflow
    press(4'd15, 1);
    chk("clr_opa", 32'(OPA), 32'h0);
    chk("clr_opb", 32'(OPB), 32'h0);
    chk("clr_disp", 32'(DISP_SEL), 32'd0);
    press(4'd9, 3);
    press(4'd8, 3);
    press(4'd7, 3);
    press(4'd6, 3);
    chk("hold_4dig", 32'(OPA), 32'h9876);
    press(4'd5, 3);
    chk("hold_5th_ignored", 32'(OPA), 32'h9876);

    // Operator edits, empty-B equals, divide-by-zero error
    press(4'd13, 1);
    chk("div_opcode", 32'(OPCODE), 32'd3);
    press_eq(4'd14, 1'b0, "emptyb_eq");
    chk("emptyb_disp", 32'(DISP_SEL), 32'd1);
    press(4'd12, 1);
    chk("op_revise_mul", 32'(OPCODE), 32'd2);
    press(4'd13, 1);
    press(4'd0, 1);
    press(4'd10, 1);
    chk("op_locked", 32'(OPCODE), 32'd3);
    chk("divz_opb", 32'(OPB), 32'h0);
    press_eq(4'd14, 1'b1, "divz_eq");
    alu_done(16'h0000, 1'b1);
    chk("errs_err", 32'(ERR), 32'd1);
    chk("errs_disp", 32'(DISP_SEL), 32'd3);
    press(4'd5, 1);
    chk("errs_dig_ignored", 32'(OPA), 32'h9876);
    press_eq(4'd14, 1'b0, "errs_eq");
    chk("errs_still", 32'(ERR), 32'd1);
    press(4'd15, 1);
    chk("errclr_err", 32'(ERR), 32'd0);
    chk("errclr_opa", 32'(OPA), 32'h0);
    chk("errclr_disp", 32'(DISP_SEL), 32'd0);
    chk("errclr_opcode", 32'(OPCODE), 32'd0);

    // Timeout: 255 EXEC cycles with no completion
    press(4'd1, 1);
    press(4'd10, 1);
    press(4'd2, 1);
    press_eq(4'd14, 1'b1, "tmo_eq");
    repeat (253) tick();
    chk("tmo_254_disp", 32'(DISP_SEL), 32'd1);
    chk("tmo_254_err", 32'(ERR), 32'd0);
    tick();
    chk("tmo_err", 32'(ERR), 32'd1);
    chk("tmo_disp", 32'(DISP_SEL), 32'd3);

    // Completion on the last allowed cycle wins over timeout
    press(4'd15, 1);
    press(4'd1, 1);
    press(4'd10, 1);
    press(4'd2, 1);
    press_eq(4'd14, 1'b1, "late_eq");
    repeat (253) tick();
    alu_done(16'h0003, 1'b0);
    chk("late_done_disp", 32'(DISP_SEL), 32'd2);
    chk("late_done_err", 32'(ERR), 32'd0);

    // Clear coincident with completion
    press_eq(4'd14, 1'b1, "clrdone_eq");
    chk("clrdone_opa", 32'(OPA), 32'h0003);
    BCDKey   = 4'd15;
    KeyRead  = 1'b1;
    ALU_DONE = 1'b1;
    RESULT   = 16'h0005;
    tick();
    ALU_DONE = 1'b0;
    KeyRead  = 1'b0;
    chk("clrdone_disp", 32'(DISP_SEL), 32'd0);
    chk("clrdone_opa0", 32'(OPA), 32'h0);
    tick();
    alu_done(16'h0000, 1'b1);
    chk("stray_done_disp", 32'(DISP_SEL), 32'd0);
    chk("stray_done_err", 32'(ERR), 32'd0);

    // Asynchronous reset in the middle of EXEC
    press(4'd7, 1);
    press(4'd12, 1);
    press(4'd8, 1);
    press_eq(4'd14, 1'b1, "arst_eq");
    chk("arst_pre_disp", 32'(DISP_SEL), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    chk("arst_opa", 32'(OPA), 32'h0);
    chk("arst_opb", 32'(OPB), 32'h0);
    chk("arst_opcode", 32'(OPCODE), 32'd0);
    chk("arst_disp", 32'(DISP_SEL), 32'd0);
    chk("arst_err", 32'(ERR), 32'd0);
    tick();
    RESET = 1'b1;
    tick();
    alu_done(16'h0056, 1'b0);
    chk("arst_done_disp", 32'(DISP_SEL), 32'd0);
    chk("arst_done_start", 32'(ALU_START), 32'd0);
    chk("arst_done_opa", 32'(OPA), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
